// File: rtl/mem_cycle_responder.sv
// Z80 memory-cycle responder: per-region wait states, registered read data,
// one-clock write strobes and the romDisable shadow-ROM latch.
module mem_cycle_responder #(
  parameter int unsigned ROM_WS       = 2,
  parameter int unsigned RAM_WS       = 0,
  parameter int unsigned VGA_WS       = 3,
  parameter logic [7:0]  ROM_OFF_PORT = 8'h1F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] port_adr,
  input  logic       rom_cs,
  input  logic       ram_cs,
  input  logic       vgaRam_cs,
  input  logic [7:0] rom_dout,
  input  logic [7:0] ram_dout,
  input  logic [7:0] vga_dout,
  output logic       wait_n,
  output logic [7:0] cpu_din,
  output logic       ram_we,
  output logic       vga_we,
  output logic       romDisable,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAITS = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_NONE = 2'd0,
    RG_ROM  = 2'd1,
    RG_RAM  = 2'd2,
    RG_VGA  = 2'd3
  } region_t;

  localparam logic [3:0] ROM_WS_C = 4'(ROM_WS);
  localparam logic [3:0] RAM_WS_C = 4'(RAM_WS);
  localparam logic [3:0] VGA_WS_C = 4'(VGA_WS);

  state_t     state_q, state_d;
  region_t    region_q, region_d;
  logic       rd_q, rd_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wait_n_q, wait_n_d;
  logic [7:0] cpu_din_q, cpu_din_d;
  logic       ram_we_q, ram_we_d;
  logic       vga_we_q, vga_we_d;
  logic       rom_dis_q, rom_dis_d;
  logic       busy_q, busy_d;

  logic       start_s;
  logic       io_off_s;
  region_t    sel_region_s;

  function automatic logic [3:0] region_ws(input region_t rg);
    case (rg)
      RG_ROM:  region_ws = ROM_WS_C;
      RG_RAM:  region_ws = RAM_WS_C;
      RG_VGA:  region_ws = VGA_WS_C;
      default: region_ws = 4'd0;
    endcase
  endfunction

  // Unmapped reads float high, as the open Z80 data bus would.
  function automatic logic [7:0] region_rdata(input region_t rg, input logic [7:0] rom_v,
                                              input logic [7:0] ram_v, input logic [7:0] vga_v);
    case (rg)
      RG_ROM:  region_rdata = rom_v;
      RG_RAM:  region_rdata = ram_v;
      RG_VGA:  region_rdata = vga_v;
      default: region_rdata = 8'hFF;
    endcase
  endfunction

  assign start_s  = !mreq_n && (!rd_n || !wr_n);
  assign io_off_s = !iorq_n && !wr_n && (port_adr == ROM_OFF_PORT);

  always_comb begin
    if (rom_cs) begin
      sel_region_s = RG_ROM;
    end else if (vgaRam_cs) begin
      sel_region_s = RG_VGA;
    end else if (ram_cs) begin
      sel_region_s = RG_RAM;
    end else begin
      sel_region_s = RG_NONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wait_n_d  = wait_n_q;
    cpu_din_d = cpu_din_q;
    ram_we_d  = 1'b0;
    vga_we_d  = 1'b0;
    rom_dis_d = io_off_s ? 1'b0 : rom_dis_q;

    case (state_q)
      ST_IDLE: begin
        wait_n_d = 1'b1;
        if (start_s) begin
          region_d = sel_region_s;
          rd_d     = !rd_n;
          cnt_d    = region_ws(sel_region_s);
          if (region_ws(sel_region_s) != 4'd0) begin
            state_d  = ST_WAITS;
            wait_n_d = 1'b0;
          end else begin
            // Zero-wait regions go straight to the transfer clock, strobe included.
            state_d  = ST_XFER;
            ram_we_d = rd_n && (sel_region_s == RG_RAM);
            vga_we_d = rd_n && (sel_region_s == RG_VGA);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAITS: begin
        if (mreq_n) begin
          state_d  = ST_IDLE;
          wait_n_d = 1'b1;
          cnt_d    = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d  = ST_XFER;
          wait_n_d = 1'b1;
          cnt_d    = 4'd0;
          ram_we_d = !rd_q && (region_q == RG_RAM);
          vga_we_d = !rd_q && (region_q == RG_VGA);
        end else begin
          wait_n_d = 1'b0;
          cnt_d    = cnt_q - 4'd1;
        end
      end
      ST_XFER: begin
        wait_n_d = 1'b1;
        state_d  = ST_HOLD;
        if (rd_q) begin
          cpu_din_d = region_rdata(region_q, rom_dout, ram_dout, vga_dout);
        end else begin
          cpu_din_d = cpu_din_q;
        end
      end
      ST_HOLD: begin
        wait_n_d = 1'b1;
        if (mreq_n) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wait_n_d = 1'b1;
        cnt_d    = 4'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      region_q  <= RG_NONE;
      rd_q      <= 1'b0;
      cnt_q     <= 4'd0;
      wait_n_q  <= 1'b1;
      cpu_din_q <= 8'hFF;
      ram_we_q  <= 1'b0;
      vga_we_q  <= 1'b0;
      rom_dis_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wait_n_q  <= wait_n_d;
      cpu_din_q <= cpu_din_d;
      ram_we_q  <= ram_we_d;
      vga_we_q  <= vga_we_d;
      rom_dis_q <= rom_dis_d;
      busy_q    <= busy_d;
    end
  end

  assign wait_n     = wait_n_q;
  assign cpu_din    = cpu_din_q;
  assign ram_we     = ram_we_q;
  assign vga_we     = vga_we_q;
  assign romDisable = rom_dis_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_cycle_responder.sv
// Scoreboard bench for mem_cycle_responder with default wait-state parameters.
module tb_mem_cycle_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] port_adr = 8'h00;
  logic       rom_cs = 1'b0, ram_cs = 1'b0, vgaRam_cs = 1'b0;
  logic [7:0] rom_dout = 8'h00, ram_dout = 8'h00, vga_dout = 8'h00;
  logic       wait_n, ram_we, vga_we, romDisable, busy;
  logic [7:0] cpu_din;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'hFF;

  mem_cycle_responder dut (
    .clock(clock), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .port_adr(port_adr), .rom_cs(rom_cs), .ram_cs(ram_cs), .vgaRam_cs(vgaRam_cs),
    .rom_dout(rom_dout), .ram_dout(ram_dout), .vga_dout(vga_dout),
    .wait_n(wait_n), .cpu_din(cpu_din), .ram_we(ram_we), .vga_we(vga_we),
    .romDisable(romDisable), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_cs(input logic r, input logic m, input logic v);
    rom_cs = r; ram_cs = m; vgaRam_cs = v;
  endtask

  // Read cycle: expected data is queued at drive time and popped when the data lands.
  task automatic mem_read(input string tag, input logic r, input logic m, input logic v,
                          input logic [7:0] exp_data, input int exp_ws, input logic swap_cs);
    int   waits = 0;
    int   strobes = 0;
    logic done = 1'b0;
    logic [7:0] exp_v;
    @(negedge clock);
    set_cs(r, m, v);
    mreq_n = 1'b0; rd_n = 1'b0;
    exp_q.push_back(exp_data);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (i == 0 && swap_cs) set_cs(1'b0, 1'b1, 1'b0);
      strobes += int'(ram_we) + int'(vga_we);
      if (!wait_n) waits++;
      else done = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_waits"}, 32'(waits), 32'(exp_ws));
    @(negedge clock);
    strobes += int'(ram_we) + int'(vga_we);
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    check_eq({tag, "_data"}, 32'(cpu_din), 32'(exp_v));
    check_eq({tag, "_busy_hold"}, 32'(busy), 32'd1);
    mreq_n = 1'b1; rd_n = 1'b1;
    set_cs(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    strobes += int'(ram_we) + int'(vga_we);
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_no_strobe"}, 32'(strobes), 32'd0);
  endtask

  task automatic mem_write(input string tag, input logic m, input logic v, input int hold,
                           input int exp_ws, input int exp_ram, input int exp_vga);
    int waits = 0;
    int rp = 0;
    int vp = 0;
    @(negedge clock);
    set_cs(1'b0, m, v);
    mreq_n = 1'b0; wr_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!wait_n) waits++;
      rp += int'(ram_we);
      vp += int'(vga_we);
    end
    mreq_n = 1'b1; wr_n = 1'b1;
    set_cs(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    rp += int'(ram_we);
    vp += int'(vga_we);
    check_eq({tag, "_waits"}, 32'(waits), 32'(exp_ws));
    check_eq({tag, "_ram_we"}, 32'(rp), 32'(exp_ram));
    check_eq({tag, "_vga_we"}, 32'(vp), 32'(exp_vga));
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_data_kept"}, 32'(cpu_din), 32'(last_rd));
  endtask

  task automatic io_out(input logic [7:0] port, input logic exp_dis, input string tag);
    @(negedge clock);
    port_adr = port; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clock);
    iorq_n = 1'b1; wr_n = 1'b1;
    check_eq(tag, 32'(romDisable), 32'(exp_dis));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int vp;
    repeat (2) @(negedge clock);
    check_eq("rst_wait_n", 32'(wait_n), 32'd1);
    check_eq("rst_cpu_din", 32'(cpu_din), 32'hFF);
    check_eq("rst_we", 32'({ram_we, vga_we}), 32'd0);
    check_eq("rst_romdis", 32'(romDisable), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // ROM read with chip selects swapped to RAM mid-cycle: region must stay latched.
    rom_dout = 8'hC3; ram_dout = 8'h3C; vga_dout = 8'h5A;
    mem_read("rom_rd", 1'b1, 1'b0, 1'b0, 8'hC3, 2, 1'b1);
    mem_write("ram_wr", 1'b1, 1'b0, 5, 0, 1, 0);
    mem_write("vga_wr", 1'b0, 1'b1, 6, 3, 0, 1);
    mem_read("ram_rd", 1'b0, 1'b1, 1'b0, 8'h3C, 0, 1'b0);
    mem_read("vga_rd", 1'b0, 1'b1, 1'b1, 8'h5A, 3, 1'b0);

    // Abort a VGA read after one wait clock.
    vga_dout = 8'h77;
    @(negedge clock);
    set_cs(1'b0, 1'b0, 1'b1);
    mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clock);
    check_eq("abort_wait_low", 32'(wait_n), 32'd0);
    mreq_n = 1'b1; rd_n = 1'b1;
    set_cs(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_eq("abort_wait_n", 32'(wait_n), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check_eq("abort_data_kept", 32'(cpu_din), 32'(last_rd));

    mem_read("none_rd", 1'b0, 1'b0, 1'b0, 8'hFF, 0, 1'b0);
    mem_write("rom_wr", 1'b0, 1'b0, 4, 0, 0, 0);

    io_out(8'h1E, 1'b1, "out_1e");
    io_out(8'h1F, 1'b0, "out_1f");
    io_out(8'h1E, 1'b0, "out_1e_sticky");

    // Reset during VGA write wait states.
    vga_dout = 8'h11;
    @(negedge clock);
    set_cs(1'b0, 1'b0, 1'b1);
    mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clock);
    check_eq("rstmid_wait_low", 32'(wait_n), 32'd0);
    reset = 1'b1;
    mreq_n = 1'b1; wr_n = 1'b1;
    set_cs(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check_eq("rstmid_wait_n", 32'(wait_n), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_cpu_din", 32'(cpu_din), 32'hFF);
    check_eq("rstmid_romdis", 32'(romDisable), 32'd1);
    reset = 1'b0;
    last_rd = 8'hFF;
    vp = int'(vga_we);
    repeat (5) begin
      @(negedge clock);
      vp += int'(vga_we);
    end
    check_eq("rstmid_no_vga_we", 32'(vp), 32'd0);

    mem_read("post_rst_rom", 1'b1, 1'b0, 1'b0, 8'hC3, 2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
